// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture block: FSM states, glyph table, decoder.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

  // Segment order a..g, segment a is bit 0 (leftmost in the literal).
  localparam logic [0:6] GLYPH_0 = 7'b1111110;
  localparam logic [0:6] GLYPH_1 = 7'b0110000;
  localparam logic [0:6] GLYPH_2 = 7'b1101101;
  localparam logic [0:6] GLYPH_3 = 7'b1111001;
  localparam logic [0:6] GLYPH_4 = 7'b0110011;
  localparam logic [0:6] GLYPH_5 = 7'b1011011;
  localparam logic [0:6] GLYPH_6 = 7'b1011111;
  localparam logic [0:6] GLYPH_7 = 7'b1110000;
  localparam logic [0:6] GLYPH_8 = 7'b1111111;
  localparam logic [0:6] GLYPH_9 = 7'b1111011;
  localparam logic [0:6] GLYPH_A = 7'b1110111;
  localparam logic [0:6] GLYPH_B = 7'b0011111;
  localparam logic [0:6] GLYPH_C = 7'b1001110;
  localparam logic [0:6] GLYPH_D = 7'b0111101;
  localparam logic [0:6] GLYPH_E = 7'b1001111;
  localparam logic [0:6] GLYPH_F = 7'b1000111;

  // Inverse glyph lookup; returns {err, nibble}, illegal patterns give {1, 0}.
  function automatic logic [4:0] seg7_decode(input logic [0:6] seg);
    case (seg)
      GLYPH_0: seg7_decode = 5'h00;
      GLYPH_1: seg7_decode = 5'h01;
      GLYPH_2: seg7_decode = 5'h02;
      GLYPH_3: seg7_decode = 5'h03;
      GLYPH_4: seg7_decode = 5'h04;
      GLYPH_5: seg7_decode = 5'h05;
      GLYPH_6: seg7_decode = 5'h06;
      GLYPH_7: seg7_decode = 5'h07;
      GLYPH_8: seg7_decode = 5'h08;
      GLYPH_9: seg7_decode = 5'h09;
      GLYPH_A: seg7_decode = 5'h0A;
      GLYPH_B: seg7_decode = 5'h0B;
      GLYPH_C: seg7_decode = 5'h0C;
      GLYPH_D: seg7_decode = 5'h0D;
      GLYPH_E: seg7_decode = 5'h0E;
      GLYPH_F: seg7_decode = 5'h0F;
      default: seg7_decode = 5'h10;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational wrapper around the shared glyph decoder.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  // Split the packed {err, nibble} result onto ports.
  always_comb begin
    {err_o, nibble_o} = seg7_decode(seg_i);
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures multiplexed 7-segment digits, debounces each, and assembles hex frames.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned NDIG          = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [0:6]          seg_in,
  input  logic [NDIG-1:0]     dig_sel,
  output logic [4*NDIG-1:0]   frame_data,
  output logic [NDIG-1:0]     frame_err,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overrun
);

  localparam int unsigned     FRAME_W    = NIB_W * NDIG;
  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);

  cap_state_e          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NDIG-1:0]     sel_q, sel_d;
  logic [0:6]          pat_q, pat_d;
  logic [NDIG-1:0]     mask_q, mask_d;
  logic [FRAME_W-1:0]  stage_data_q, stage_data_d;
  logic [NDIG-1:0]     stage_err_q, stage_err_d;
  logic [FRAME_W-1:0]  frame_data_q, frame_data_d;
  logic [NDIG-1:0]     frame_err_q, frame_err_d;
  logic                frame_valid_q, frame_valid_d;
  logic                overrun_q, overrun_d;

  logic                sel_onehot;
  logic                sample_match;
  logic                restart;
  logic                counting;
  logic                accept;
  logic [3:0]          dec_nibble;
  logic                dec_err;

  assign sel_onehot   = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
  assign sample_match = (dig_sel == sel_q) && (seg_in == pat_q);

  // pat_d is the pattern held in the latch after this edge; on acceptance it equals seg_in.
  seg7_glyph_decode u_decode (
    .seg_i    (pat_d),
    .nibble_o (dec_nibble),
    .err_o    (dec_err)
  );

  // Capture FSM: settle on a stable (dig_sel, seg_in) pair, then lock until dig_sel moves.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sel_d    = sel_q;
    pat_d    = pat_q;
    restart  = 1'b0;
    counting = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE:    restart = 1'b1;
      SETTLE: begin
        if (sample_match) begin
          count_d  = count_q + CNT_W'(1);
          counting = 1'b1;
        end else begin
          restart = 1'b1;
        end
      end
      LOCKED:  restart = (dig_sel != sel_q);
      default: state_d = IDLE;
    endcase
    if (restart) begin
      if (sel_onehot) begin
        sel_d    = dig_sel;
        pat_d    = seg_in;
        count_d  = CNT_W'(1);
        state_d  = SETTLE;
        counting = 1'b1;
      end else begin
        state_d = IDLE;
        count_d = '0;
      end
    end
    if (counting && (count_d == STABLE_LIM)) begin
      accept  = 1'b1;
      state_d = LOCKED;
    end
  end

  // Staging/mask update and frame hand-off with overrun detection.
  always_comb begin
    mask_d        = mask_q;
    stage_data_d  = stage_data_q;
    stage_err_d   = stage_err_q;
    frame_data_d  = frame_data_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = 1'b0;
    if (&mask_q) begin
      mask_d = '0;
      if (!frame_valid_q || frame_ready) begin
        frame_data_d  = stage_data_q;
        frame_err_d   = stage_err_q;
        frame_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
    if (accept) begin
      mask_d = mask_d | sel_d;
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (sel_d[i]) begin
          stage_data_d[NIB_W*i +: NIB_W] = dec_nibble;
          stage_err_d[i]                 = dec_err;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      sel_q         <= '0;
      pat_q         <= '0;
      mask_q        <= '0;
      stage_data_q  <= '0;
      stage_err_q   <= '0;
      frame_data_q  <= '0;
      frame_err_q   <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sel_q         <= sel_d;
      pat_q         <= pat_d;
      mask_q        <= mask_d;
      stage_data_q  <= stage_data_d;
      stage_err_q   <= stage_err_d;
      frame_data_q  <= frame_data_d;
      frame_err_q   <= frame_err_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_err   = frame_err_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized and directed bench for seg7_capture against a cycle-level reference model.
module tb_seg7_capture;

  localparam int unsigned STABLE = 4;
  localparam int unsigned NDIG   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  seg_in;
  logic [3:0]  dig_sel;
  logic        frame_ready;
  logic [15:0] frame_data;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        overrun;

  seg7_capture #(.STABLE_CYCLES(STABLE), .NDIG(NDIG)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  logic [0:6] glyph_tb [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_streak;
  logic [3:0]  m_psel;
  logic [0:6]  m_pseg;
  bit          m_done;
  logic [3:0]  m_lock_sel;
  logic [3:0]  m_mask;
  logic [15:0] m_stage;
  logic [3:0]  m_stage_err;
  logic [15:0] e_data;
  logic [3:0]  e_err;
  bit          e_valid;
  bit          e_ovr;

  // Observation bookkeeping for directed scenarios
  int          n_valid;
  int          n_ovr;
  logic [15:0] last_data;
  logic [3:0]  last_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Search the glyph table; anything not found is illegal.
  function automatic logic [4:0] ref_decode(input logic [0:6] seg);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++)
      if (glyph_tb[i] == seg) r = 5'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_streak = 0; m_psel = '0; m_pseg = '0; m_done = 0; m_lock_sel = '0;
    m_mask = '0; m_stage = '0; m_stage_err = '0;
    e_data = '0; e_err = '0; e_valid = 0; e_ovr = 0;
  endtask

  task automatic model_edge(input logic [3:0] sel, input logic [0:6] seg, input bit rdy);
    bit acc;
    logic [4:0] d;
    acc   = 0;
    e_ovr = 0;
    if (m_mask == 4'hF) begin
      m_mask = '0;
      if (!e_valid || rdy) begin
        e_data = m_stage; e_err = m_stage_err; e_valid = 1;
      end else begin
        e_ovr = 1;
      end
    end else if (e_valid && rdy) begin
      e_valid = 0;
    end
    if (!(m_done && sel == m_lock_sel)) begin
      m_done = 0;
      if ($countones(sel) != 1) m_streak = 0;
      else if (m_streak > 0 && sel == m_psel && seg == m_pseg) m_streak++;
      else m_streak = 1;
      m_psel = sel;
      m_pseg = seg;
      if (m_streak == STABLE) begin
        acc = 1; m_done = 1; m_lock_sel = sel;
      end
    end
    if (acc) begin
      d = ref_decode(m_pseg);
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          m_mask[i]          = 1'b1;
          m_stage[4*i +: 4]  = d[3:0];
          m_stage_err[i]     = d[4];
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] sel, input logic [0:6] seg, input bit rdy);
    dig_sel     = sel;
    seg_in      = seg;
    frame_ready = rdy;
    @(posedge clk);
    model_edge(sel, seg, rdy);
    #1;
    check_eq("frame_valid", 32'(frame_valid), 32'(e_valid));
    check_eq("overrun",     32'(overrun),     32'(e_ovr));
    check_eq("frame_data",  32'(frame_data),  32'(e_data));
    check_eq("frame_err",   32'(frame_err),   32'(e_err));
    if (frame_valid) begin
      n_valid++;
      last_data = frame_data;
      last_err  = frame_err;
    end
    if (overrun) n_ovr++;
  endtask

  task automatic send_digit(input int idx, input logic [0:6] seg, input int hold, input bit rdy);
    logic [3:0] s;
    s = 4'(1) << idx;
    for (int k = 0; k < hold; k++) step(s, seg, rdy);
  endtask

  task automatic send_frame(input logic [15:0] val, input bit rdy);
    for (int d = 0; d < 4; d++) send_digit(d, glyph_tb[val[4*d +: 4]], STABLE, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(4'b0000, 7'b0000000, rdy);
  endtask

  task automatic clear_obs();
    n_valid = 0; n_ovr = 0; last_data = '0; last_err = '0;
  endtask

  initial begin
    logic [0:6] pat;
    int d;
    rst = 1'b1; dig_sel = '0; seg_in = '0; frame_ready = 1'b0;
    model_reset();
    clear_obs();
    #2;
    check_eq("reset_data",  32'(frame_data),  32'h0);
    check_eq("reset_valid", 32'(frame_valid), 32'h0);
    @(posedge clk); #1;
    check_eq("reset_err",   32'(frame_err),   32'h0);
    check_eq("reset_ovr",   32'(overrun),     32'h0);
    rst = 1'b0;

    // Basic frame 4321 with ready high
    clear_obs();
    send_frame(16'h4321, 1'b1);
    idle(3, 1'b1);
    check_eq("basic_data",   32'(last_data), 32'h4321);
    check_eq("basic_err",    32'(last_err),  32'h0);
    check_eq("basic_vcount", 32'(n_valid),   32'd1);

    // Glitch on digit 0: only the final stable pattern counts
    clear_obs();
    send_digit(0, glyph_tb[7], 3, 1'b1);
    send_digit(0, glyph_tb[5], STABLE, 1'b1);
    send_digit(1, glyph_tb[6], STABLE, 1'b1);
    send_digit(2, glyph_tb[8], STABLE, 1'b1);
    send_digit(3, glyph_tb[9], STABLE, 1'b1);
    idle(3, 1'b1);
    check_eq("glitch_data", 32'(last_data), 32'h9865);

    // Illegal pattern on digit 2
    clear_obs();
    send_digit(0, glyph_tb[1], STABLE, 1'b1);
    send_digit(1, glyph_tb[2], STABLE, 1'b1);
    send_digit(2, 7'b0000001, STABLE, 1'b1);
    send_digit(3, glyph_tb[3], STABLE, 1'b1);
    idle(3, 1'b1);
    check_eq("illegal_data", 32'(last_data), 32'h3021);
    check_eq("illegal_err",  32'(last_err),  32'h4);

    // Back-pressure: second frame dropped with one overrun pulse
    clear_obs();
    send_frame(16'hABCD, 1'b0);
    idle(2, 1'b0);
    send_frame(16'h1234, 1'b0);
    idle(2, 1'b0);
    check_eq("ovr_count", 32'(n_ovr),       32'd1);
    check_eq("ovr_data",  32'(frame_data),  32'hABCD);
    check_eq("ovr_valid", 32'(frame_valid), 32'h1);
    step(4'b0000, 7'b0000000, 1'b1);
    check_eq("ovr_drop",  32'(frame_valid), 32'h0);

    // Non-one-hot select leaves partial mask intact
    clear_obs();
    send_digit(0, glyph_tb[5], STABLE, 1'b1);
    send_digit(1, glyph_tb[6], STABLE, 1'b1);
    send_digit(2, glyph_tb[7], STABLE, 1'b1);
    for (int k = 0; k < 10; k++) step((k % 2 == 0) ? 4'b0011 : 4'b0000, glyph_tb[1], 1'b1);
    check_eq("bad_sel_noframe", 32'(n_valid), 32'd0);
    send_digit(3, glyph_tb[8], STABLE, 1'b1);
    idle(3, 1'b1);
    check_eq("bad_sel_data", 32'(last_data), 32'h8765);

    // Asynchronous reset mid-settle with a frame pending
    clear_obs();
    send_frame(16'hE0F1, 1'b0);
    idle(2, 1'b0);
    send_digit(0, glyph_tb[2], 2, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_data",  32'(frame_data),  32'h0);
    check_eq("arst_err",   32'(frame_err),   32'h0);
    check_eq("arst_valid", 32'(frame_valid), 32'h0);
    check_eq("arst_ovr",   32'(overrun),     32'h0);
    model_reset();
    dig_sel = '0; seg_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    send_frame(16'h5A6B, 1'b1);
    idle(3, 1'b1);
    check_eq("arst_after", 32'(last_data), 32'h5A6B);

    // Randomized traffic
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 6; k++) begin
        d = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0)
          send_digit(d, 7'($urandom), int'($urandom_range(1, STABLE - 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 7) == 0) pat = 7'($urandom);
        else pat = glyph_tb[$urandom_range(0, 15)];
        for (int h = 0; h < int'(STABLE + $urandom_range(0, 2)); h++)
          step(4'(1) << d, pat, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0)
          step(($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0101, 7'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    idle(4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples needed to accept a digit (legal range 1..255).
REQ-002 SHALL have parameter NDIG, default 4, number of display digits scanned.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 seg_in  input  [0:6]  segment bus, active-high, bit 0 = segment a ... bit 6 = segment g.
REQ-006 dig_sel  input  [NDIG-1:0]  digit enable from the display multiplexer, one-hot when legal.
REQ-007 frame_data  output  [4*NDIG-1:0]  decoded hex nibbles, digit i in bits [4i+3:4i].
REQ-008 frame_err  output  [NDIG-1:0]  per-digit flag: last accepted pattern of digit i was not a legal glyph.
REQ-009 frame_valid  output  1  frame available; held until accepted.
REQ-010 frame_ready  input  1  consumer accepts frame when frame_valid && frame_ready.
REQ-011 overrun  output  1  one-cycle pulse: completed frame dropped because the previous frame was still pending.

Function
REQ-012 SHALL decode the inverse of the team's 7-segment encoding (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-013 SHALL treat any other pattern as illegal: nibble 4'h0, err bit 1.
REQ-014 SHALL run a capture FSM with states IDLE, SETTLE, LOCKED.
REQ-015 IDLE: dig_sel not one-hot -> stay; one-hot -> SETTLE, latch dig_sel and seg_in, count=1.
REQ-016 SETTLE: dig_sel and seg_in equal to latched values -> count+1; otherwise restart SETTLE with new values (or IDLE if dig_sel not one-hot).
REQ-017 SETTLE: in the cycle count reaches STABLE_CYCLES -> accept digit (write nibble/err to staging slot, set mask bit), go to LOCKED; with STABLE_CYCLES=1 acceptance occurs on the first sample.
REQ-018 LOCKED: stay while dig_sel unchanged (seg_in changes ignored); on dig_sel change -> IDLE/SETTLE per REQ-015 rules in that same cycle.
REQ-019 Re-accepting a digit already in the mask SHALL overwrite its staging slot.
REQ-020 When the mask becomes all-ones, next cycle SHALL copy staging to frame_data/frame_err, clear mask, assert frame_valid (latency: acceptance of last digit + 1 cycle).
REQ-021 If frame_valid && !frame_ready at completion, outputs SHALL hold, the new frame is discarded, overrun pulses, mask clears.
REQ-022 If frame_ready is high in the completion cycle, the pending frame is consumed and the new one loaded with frame_valid staying high; no overrun.
REQ-023 frame_valid SHALL drop the cycle after handshake when no new frame loads.

Reset
REQ-024 rst high SHALL immediately force FSM=IDLE, count=0, mask=0, staging=0, frame_data=0, frame_err=0, frame_valid=0, overrun=0.
REQ-025 Reset mid-SETTLE or with a pending frame SHALL discard all partial and pending data; capture restarts on first legal dig_sel after release.

Structure
REQ-026 Shared package seg7_pkg SHALL hold the FSM state typedef, the glyph constants and a decode function returning {err, nibble}; reuse by the existing encoder bench for checking.
REQ-027 One sub-module seg7_glyph_decode (combinational, wraps the package function) SHALL be instantiated once on the latched pattern.

Verification
REQ-028 dig_sel 0001, seg_in 0110000 held 4 cycles, then 0010/1101101, 0100/1111001, 1000/0110011 each 4 cycles, ready=1 -> frame_data 16'h4321, frame_err 0, one-cycle frame_valid.
REQ-029 Digit 0 pattern toggles after 3 cycles, then stable 4 -> only final pattern accepted; glitch value never appears.
REQ-030 Digit 2 pattern 0000001 -> frame_err 4'b0100, nibble 2 = 0.
REQ-031 ready=0, two full frames 16'hABCD then 16'h1234 -> frame_data stays ABCD, overrun pulses once; raise ready -> valid drops next cycle.
REQ-032 dig_sel 0011 or 0000 for 10 cycles -> FSM remains IDLE, mask unchanged.
REQ-033 Assert rst mid-SETTLE with a frame pending -> all outputs 0 asynchronously; full frame afterwards captured correctly.
